// File: rtl/note_sequencer.sv
// Note sequencer: steps through a small table of {divider, duration} notes
// and drives the PWM sine generator's divider input.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tempo           clocks per beat minus 1, sampled at each beat reload
//   wr_en/wr_addr   table write strobe and address
//   wr_div/wr_dur   table write data (divider, duration in beats minus 1)
//   len, loop       last entry index played; wrap to entry 0 when loop=1
//   start, stop     level-sampled playback control, stop wins
//   divider, gate   current note divider and non-rest indication
//   busy            high while playing
//   step_idx        index of the current note
//   note_strobe     one-cycle pulse when a new note is presented

module note_sequencer #(
   parameter int DIV_W   = 12,
   parameter int DUR_W   = 4,
   parameter int TEMPO_W = 16,
   parameter int AW      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TEMPO_W-1:0] tempo,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DIV_W-1:0]   wr_div,
   input  logic [DUR_W-1:0]   wr_dur,
   input  logic [AW-1:0]      len,
   input  logic               loop,
   input  logic               start,
   input  logic               stop,
   output logic [DIV_W-1:0]   divider,
   output logic               gate,
   output logic               busy,
   output logic [AW-1:0]      step_idx,
   output logic               note_strobe
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DIV_W-1:0]   tbl_div [DEPTH];
   logic [DUR_W-1:0]   tbl_dur [DEPTH];

   logic [TEMPO_W-1:0] beat_q;
   logic [TEMPO_W-1:0] beat_d;
   logic [DUR_W-1:0]   dur_q;
   logic [DUR_W-1:0]   dur_d;
   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   div_d;
   logic               gate_q;
   logic               gate_d;
   logic [AW-1:0]      idx_q;
   logic [AW-1:0]      idx_d;
   logic               stb_q;
   logic               stb_d;

   logic               do_load;
   logic               do_clear;
   logic [AW-1:0]      load_idx;
   logic               beat_tick;
   logic               note_done;

   assign beat_tick = (beat_q == '0);
   assign note_done = beat_tick && (dur_q == '0);

   // Table: writes allowed in any state. A load on the same edge as a
   // write to the same entry reads the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_div[i] <= '0;
            tbl_dur[i] <= '0;
         end
      end else if (wr_en) begin
         tbl_div[wr_addr] <= wr_div;
         tbl_dur[wr_addr] <= wr_dur;
      end
   end

   // Next-state decision. stop beats start, start beats note expiry.
   always_comb begin
      state_d  = state_q;
      do_load  = 1'b0;
      do_clear = 1'b0;
      load_idx = '0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = PLAY;
               do_load = 1'b1;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d  = IDLE;
               do_clear = 1'b1;
            end else if (start) begin
               do_load = 1'b1;
            end else if (note_done) begin
               if (idx_q != len) begin
                  do_load  = 1'b1;
                  load_idx = idx_q + 1'b1;
               end else if (loop) begin
                  do_load = 1'b1;
               end else begin
                  state_d  = IDLE;
                  do_clear = 1'b1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            do_clear = 1'b1;
         end
      endcase
   end

   // Datapath next values.
   always_comb begin
      beat_d = beat_q;
      dur_d  = dur_q;
      div_d  = div_q;
      gate_d = gate_q;
      idx_d  = idx_q;
      stb_d  = 1'b0;
      if (do_clear) begin
         beat_d = '0;
         dur_d  = '0;
         div_d  = '0;
         gate_d = 1'b0;
         idx_d  = '0;
      end else if (do_load) begin
         idx_d  = load_idx;
         div_d  = tbl_div[load_idx];
         dur_d  = tbl_dur[load_idx];
         beat_d = tempo;
         gate_d = |tbl_div[load_idx];
         stb_d  = 1'b1;
      end else if (state_q == PLAY) begin
         // A tick with dur 0 is an expiry, handled above as load/clear,
         // so here a tick always has dur_q > 0.
         if (beat_tick) begin
            beat_d = tempo;
            dur_d  = dur_q - 1'b1;
         end else begin
            beat_d = beat_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         dur_q   <= '0;
         div_q   <= '0;
         gate_q  <= 1'b0;
         idx_q   <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         dur_q   <= dur_d;
         div_q   <= div_d;
         gate_q  <= gate_d;
         idx_q   <= idx_d;
         stb_q   <= stb_d;
      end
   end

   assign divider     = div_q;
   assign gate        = gate_q;
   assign busy        = (state_q == PLAY);
   assign step_idx    = idx_q;
   assign note_strobe = stb_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: directed scenarios plus randomized
// traffic, checked against a note-length based reference model.

module tb_note_sequencer;

   logic        clk;
   logic        rst_n;
   logic [15:0] tempo;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [11:0] wr_div;
   logic [3:0]  wr_dur;
   logic [2:0]  len;
   logic        loop;
   logic        start;
   logic        stop;
   logic [11:0] divider;
   logic        gate;
   logic        busy;
   logic [2:0]  step_idx;
   logic        note_strobe;

   int checks;
   int failures;

   // Reference model: each note simply lasts (dur+1)*(tempo+1) clocks.
   int m_div [8];
   int m_dur [8];
   bit m_busy;
   int m_idx;
   int m_dv;
   int m_left;
   bit m_stb;

   note_sequencer dut (
      .clk(clk),
      .rst_n(rst_n),
      .tempo(tempo),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_div(wr_div),
      .wr_dur(wr_dur),
      .len(len),
      .loop(loop),
      .start(start),
      .stop(stop),
      .divider(divider),
      .gate(gate),
      .busy(busy),
      .step_idx(step_idx),
      .note_strobe(note_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 8; i++) begin
         m_div[i] = 0;
         m_dur[i] = 0;
      end
      m_busy = 0;
      m_idx  = 0;
      m_dv   = 0;
      m_left = 0;
      m_stb  = 0;
   endfunction

   function automatic void m_clear();
      m_busy = 0;
      m_idx  = 0;
      m_dv   = 0;
      m_left = 0;
   endfunction

   function automatic void m_load(input int i);
      m_busy = 1;
      m_idx  = i;
      m_dv   = m_div[i];
      m_left = (m_dur[i] + 1) * (int'(tempo) + 1);
      m_stb  = 1;
   endfunction

   function automatic void m_edge();
      m_stb = 0;
      if (!m_busy) begin
         if (start && !stop) m_load(0);
      end else if (stop) begin
         m_clear();
      end else if (start) begin
         m_load(0);
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (m_idx != int'(len)) m_load((m_idx + 1) % 8);
            else if (loop) m_load(0);
            else m_clear();
         end
      end
      if (wr_en) begin
         m_div[wr_addr] = wr_div;
         m_dur[wr_addr] = wr_dur;
      end
   endfunction

   task automatic check_all();
      chk("divider", divider, m_dv);
      chk("gate", gate, (m_busy && m_dv != 0));
      chk("busy", busy, m_busy);
      chk("step_idx", step_idx, m_idx);
      chk("note_strobe", note_strobe, m_stb);
   endtask

   task automatic cyc();
      @(posedge clk);
      m_edge();
      #1;
      check_all();
   endtask

   task automatic wr(input int a, input int d, input int u);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_div  = 12'(d);
      wr_dur  = 4'(u);
      cyc();
      wr_en   = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      tempo    = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_div   = '0;
      wr_dur   = '0;
      len      = '0;
      loop     = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      m_reset();

      // Reset state.
      #12;
      chk("rst_divider", divider, 0);
      chk("rst_gate", gate, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", step_idx, 0);
      chk("rst_strobe", note_strobe, 0);
      rst_n = 1'b1;

      // Cleared table played back: all rests.
      len   = 3'd7;
      tempo = 16'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("rd_gate", gate, 0);
         chk("rd_div", divider, 0);
         cyc();
      end

      // One-shot timing.
      wr(0, 'h100, 1);
      wr(1, 'h200, 0);
      wr(2, 'h000, 2);
      tempo = 16'd3;
      len   = 3'd2;
      loop  = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int t = 0; t <= 30; t++) begin
         if (t > 0) cyc();
         chk("os_strobe", note_strobe, (t == 0 || t == 8 || t == 12));
         chk("os_busy", busy, (t < 24));
         chk("os_gate", gate, (t < 12));
         chk("os_div", divider,
             (t < 8) ? 'h100 : (t < 12) ? 'h200 : 0);
      end

      // Loop wrap at minimum note length.
      wr(0, 'h0A0, 0);
      wr(1, 'h0B0, 0);
      tempo = 16'd0;
      len   = 3'd1;
      loop  = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk("lp_idx", step_idx, k % 2);
         chk("lp_strobe", note_strobe, 1);
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("lp_stop", busy, 0);

      // start and stop together in IDLE: stays idle.
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      chk("prio_busy", busy, 0);
      chk("prio_strobe", note_strobe, 0);

      // Restart mid-note of entry 1.
      tempo = 16'd3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) cyc();
      chk("rs_pre_idx", step_idx, 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("rs_idx", step_idx, 0);
      chk("rs_strobe", note_strobe, 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;

      // Write collision with the load of entry 1.
      wr(0, 'h111, 0);
      wr(1, 'h222, 0);
      tempo = 16'd2;
      len   = 3'd1;
      loop  = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      wr(1, 'h333, 0);
      chk("col_old", divider, 'h222);
      chk("col_idx", step_idx, 1);
      for (int k = 4; k <= 9; k++) cyc();
      chk("col_new", divider, 'h333);
      stop = 1'b1;
      cyc();
      stop = 1'b0;

      // Asynchronous reset mid-note.
      tempo = 16'd1000;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("ar_busy", busy, 0);
      chk("ar_div", divider, 0);
      check_all();
      #1;
      rst_n = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("ar_play_busy", busy, 1);
      chk("ar_play_div", divider, 0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;

      // Randomized traffic; tempo only changes while idle.
      for (int n = 0; n < 3000; n++) begin
         wr_en   = ($urandom % 4) == 0;
         wr_addr = 3'($urandom);
         wr_div  = (($urandom % 4) == 0) ? 12'd0 : 12'($urandom);
         wr_dur  = 4'($urandom % 4);
         start   = ($urandom % 40) == 0;
         stop    = ($urandom % 60) == 0;
         if (($urandom % 20) == 0) len = 3'($urandom);
         if (($urandom % 30) == 0) loop = 1'($urandom);
         if (!m_busy) tempo = 16'($urandom % 4);
         cyc();
      end
      wr_en = 1'b0;
      start = 1'b0;
      stop  = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
